muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_negate.sv | 14 +
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter value of the final CALC iteration
  localparam logic [4:0] ITER_LAST = 5'd31;

  // rs1 is interpreted as signed
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is interpreted as signed
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation; used for operand magnitudes and
// for the final sign correction of product, quotient and remainder.
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  // Pass through or negate
  always_comb dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: one shared 32-step shift-add / restoring
// shift-subtract datapath, followed by a single sign-fix cycle.
//
// Handshake: start is accepted on a rising edge while in IDLE or DONE
// (unless kill is high); busy is high while an accepted operation is in
// flight; done is high for exactly one cycle when result has been updated.
// result holds its value between completions.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output state_t          dbg_state
);

  state_t                    state;
  logic [$clog2(ITER)-1:0]   count;
  logic [2:0]                op;
  logic                      neg_res;
  logic                      special;
  logic [XLEN-1:0]           spec_val;
  // acc_hi: product high half / partial remainder
  // acc_lo: multiplier being consumed / dividend shifting into quotient
  // opnd:   multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]           acc_hi, acc_lo, opnd;

  // Start-cycle decode: sign flags, magnitudes, special cases
  logic            sa, sb, b_zero, ovf, spec_new, neg_new;
  logic [XLEN-1:0] mag_a, mag_b, spec_val_new;

  // Classify the incoming operation
  always_comb begin
    sa       = rs1_signed(funct3) & a[XLEN-1];
    sb       = rs2_signed(funct3) & b[XLEN-1];
    b_zero   = (b == '0);
    ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    spec_new = funct3[2] & (b_zero | ovf);
    // Remainder follows the dividend sign; everything else the sign product
    neg_new  = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
    spec_val_new = '0;
    if (b_zero)   spec_val_new = funct3[1] ? a : '1;
    else if (ovf) spec_val_new = funct3[1] ? '0 : a;
  end

  muldiv_negate #(.W(XLEN)) u_mag_a (.din(a), .neg(sa), .dout(mag_a));
  muldiv_negate #(.W(XLEN)) u_mag_b (.din(b), .neg(sb), .dout(mag_b));

  // One iteration of shift-add (multiply) and restoring shift-subtract (divide)
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // When the subtraction succeeds the difference is below opnd, so the
    // low XLEN bits are exact
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
  end

  // Sign correction for the FIX cycle
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   fix_val;

  // Select the quantity to correct and the half to write back
  always_comb begin
    if (!op[2])     fix_in = {acc_hi, acc_lo};
    else if (op[1]) fix_in = {{XLEN{1'b0}}, acc_hi};
    else            fix_in = {{XLEN{1'b0}}, acc_lo};
    fix_val = (op[2] || (op == F3_MUL)) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
  end

  muldiv_negate #(.W(2*XLEN)) u_fix (.din(fix_in), .neg(neg_res), .dout(fix_out));

  // Control FSM and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      count    <= '0;
      op       <= F3_MUL;
      neg_res  <= 1'b0;
      special  <= 1'b0;
      spec_val <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      result   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !kill) begin
            op       <= funct3;
            neg_res  <= neg_new;
            special  <= spec_new;
            spec_val <= spec_val_new;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= funct3[2] ? mag_a : mag_b;
            opnd     <= funct3[2] ? mag_b : mag_a;
            state    <= spec_new ? ST_FIX : ST_CALC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            if (op[2]) begin
              acc_hi <= div_rem;
              acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            count <= count + 1'b1;
            if (count == ITER_LAST) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            result <= special ? spec_val : fix_val;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status decode straight from the state register
  always_comb begin
    busy      = (state == ST_CALC) || (state == ST_FIX);
    done      = (state == ST_DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, randomized operations
// against a wide-arithmetic reference, back-to-back, kill and reset aborts.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        CLK, RST, start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  state_t      dbg_state;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width signed/unsigned arithmetic straight from the ISA rules
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, p;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    pu = {32'd0, x} * {32'd0, y};
    p  = 0;
    case (f3)
      F3_MUL:    begin p = sx * sy; return p[31:0]; end
      F3_MULH:   begin p = sx * sy; return p[63:32]; end
      F3_MULHSU: begin p = sx * uy; return p[63:32]; end
      F3_MULHU:  return pu[63:32];
      F3_DIV:    begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
      F3_DIVU:   begin if (y == 0) return 32'hFFFF_FFFF; p = ux / uy; return p[31:0]; end
      F3_REM:    begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
      default:   begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (!f3[2]) return 1'b0;
    if (y == 0) return 1'b1;
    return ((f3 == F3_DIV) || (f3 == F3_REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every done pulse pops one expectation
  always @(negedge CLK) begin
    if (!RST && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int          c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("result", result, e);
        check("done_cycle", cyc, c);
        last_res = e;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       input bit push, input logic [31:0] ev);
    @(negedge CLK);
    funct3 = f3; a = av; b = bv; start = 1'b1;
    @(posedge CLK); #1;
    if (push) begin
      exp_q.push_back(ev);
      cyc_q.push_back(cyc + (is_special(f3, av, bv) ? 1 : 33));
    end
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    a      = $urandom;
    b      = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Directed vectors with hand-derived expectations
  localparam int ND = 11;
  logic [2:0]  d_f3  [ND] = '{F3_MULHU, F3_MULH, F3_MULHSU, F3_DIV, F3_REM, F3_DIVU,
                              F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
  logic [31:0] d_a   [ND] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [ND] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [ND] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h00000000};

  // ---------------- main sequence ----------------
  initial begin
    int nd;
    RST = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    RST = 1'b0;

    // MUL 7 * -3 with busy/done timeline
    issue(F3_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB);
    check("busy_after_e0", 32'(busy), 32'd1);
    check("done_after_e0", 32'(done), 32'd0);
    repeat (32) @(posedge CLK);
    #1;
    check("busy_in_fix", 32'(busy), 32'd1);
    check("done_in_fix", 32'(done), 32'd0);
    @(posedge CLK); #1;
    check("busy_in_done", 32'(busy), 32'd0);
    check("done_in_done", 32'(done), 32'd1);
    drain();

    for (int i = 0; i < ND; i++) begin
      issue(d_f3[i], d_a[i], d_b[i], 1'b1, d_exp[i]);
      drain();
    end

    // Back-to-back: new MUL accepted while done is high, start ignored in CALC
    issue(F3_DIVU, 32'd100, 32'd7, 1'b1, 32'd14);
    repeat (33) @(posedge CLK);
    issue(F3_MUL, 32'd3, 32'd5, 1'b1, 32'd15);
    repeat (5) @(negedge CLK);
    start = 1'b1; funct3 = F3_MULHU; a = $urandom; b = $urandom;
    @(negedge CLK);
    start = 1'b0;
    nd = n_done;
    drain();
    repeat (40) @(negedge CLK);
    check("b2b_done_count", 32'(n_done - nd), 32'd1);

    // kill at count 10
    issue(F3_DIVU, $urandom, 32'd3, 1'b0, '0);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    kill = 1'b1;
    @(posedge CLK); #1;
    kill = 1'b0;
    check("kill_calc_busy", 32'(busy), 32'd0);
    nd = n_done;
    repeat (40) @(negedge CLK);
    check("kill_calc_no_done", 32'(n_done - nd), 32'd0);
    check("kill_calc_result", result, last_res);

    // kill in DONE drops a coincident start
    issue(F3_REMU, 32'd1000, 32'd33, 1'b1, 32'd10);
    repeat (33) @(posedge CLK);
    @(negedge CLK);
    kill = 1'b1; start = 1'b1; funct3 = F3_MUL; a = 32'd9; b = 32'd9;
    @(posedge CLK); #1;
    kill = 1'b0; start = 1'b0;
    check("kill_done_busy", 32'(busy), 32'd0);
    nd = n_done;
    repeat (40) @(negedge CLK);
    check("kill_done_no_done", 32'(n_done - nd), 32'd0);
    check("kill_done_result", result, 32'd10);
    drain();

    // Randomized operations
    for (int i = 0; i < 48; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = 3'($urandom_range(0, 7));
      x = pick_operand();
      y = pick_operand();
      issue(f, x, y, 1'b1, ref_model(f, x, y));
      drain();
    end

    // Asynchronous reset at count 20
    issue(F3_MULHU, $urandom | 32'h1, $urandom | 32'h1, 1'b0, '0);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    last_res = '0;
    @(negedge CLK);
    RST = 1'b0;
    issue(F3_DIVU, 32'd9, 32'd3, 1'b1, 32'd3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
